// File: rtl/ternary_pkg.sv
// Shared ternary digit codes, complement mode selectors and FSM state encoding.
package ternary_pkg;

  localparam logic [1:0] T_ZERO    = 2'b00;
  localparam logic [1:0] T_ONE     = 2'b01;
  localparam logic [1:0] T_TWO     = 2'b10;
  localparam logic [1:0] T_ILLEGAL = 2'b11;

  localparam logic MODE_DIMINISHED = 1'b0;
  localparam logic MODE_RADIX      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ternary_digit_complement.sv
// One ternary digit of the complement: (2 - d) + carry_in, folded back into a
// digit and a carry. The illegal code 11 is flagged and processed as digit 0.
module ternary_digit_complement
  import ternary_pkg::*;
(
  input  logic [1:0] digit,
  input  logic       carry_in,
  output logic [1:0] digit_out,
  output logic       carry_out,
  output logic       illegal
);

  logic [1:0] w_d;
  logic [2:0] w_sum;

  always_comb begin
    illegal   = (digit == T_ILLEGAL);
    w_d       = illegal ? T_ZERO : digit;
    w_sum     = {1'b0, T_TWO - w_d} + {2'b00, carry_in};
    digit_out = w_sum[1:0];
    carry_out = 1'b0;
    if (w_sum == 3'd3) begin
      digit_out = T_ZERO;
      carry_out = 1'b1;
    end
  end

endmodule

// File: rtl/ternary_complement_serial.sv
// Digit-serial 2's/3's complement of an N-digit ternary operand, one digit per
// cycle LSB first; result held with out_valid until the consumer takes it.
module ternary_complement_serial
  import ternary_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*N-1:0] in_data,
  input  logic           in_mode,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*N-1:0] out_data,
  output logic           out_carry,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_data;
  logic             r_carry;
  logic [2*N-1:0]   r_out_data;
  logic             r_out_carry;
  logic             r_out_err;

  logic             w_last;
  logic [1:0]       w_digit;
  logic [1:0]       w_digit_out;
  logic             w_carry_out;
  logic             w_illegal;

  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_digit = r_data[2*r_cnt +: 2];

  ternary_digit_complement u_digit (
    .digit     (w_digit),
    .carry_in  (r_carry),
    .digit_out (w_digit_out),
    .carry_out (w_carry_out),
    .illegal   (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Result digits are written in place; every digit is rewritten before DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_data      <= '0;
      r_carry     <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_data    <= in_data;
      r_cnt     <= '0;
      r_carry   <= (in_mode == MODE_RADIX);
      r_out_err <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_out_data[2*r_cnt +: 2] <= w_digit_out;
      r_carry                  <= w_carry_out;
      r_out_err                <= r_out_err | w_illegal;
      if (w_last) r_out_carry <= w_carry_out;
      else        r_cnt       <= r_cnt + CW'(1);
    end
  end

  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;
  assign out_err   = r_out_err;

endmodule
